// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu_pipelined front end.
// Holds the fetch FSM states, the NOP/end encodings and a saturating counter helper.
package cpu_pkg;

  localparam int XLEN = 64;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] END_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } fetch_state_e;

  // Counters stick at all-ones rather than wrapping to zero.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_reg_if_id.sv
// IF/ID pipeline register: reset > flush (NOP bubble) > load > hold.
// The PC field is left untouched on a flush; only the instruction and valid bit are cleared.
module pipe_reg_if_id
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  logic [XLEN-1:0] pc_r;
  logic [31:0]     instr_r;
  logic            valid_r;

  // IF/ID storage update.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r    <= {XLEN{1'b0}};
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
    end else if (flush) begin
      instr_r <= NOP_INSTR;
      valid_r <= 1'b0;
    end else if (load) begin
      pc_r    <= pc_in;
      instr_r <= instr_in;
      valid_r <= 1'b1;
    end else begin
      pc_r    <= pc_r;
      instr_r <= instr_r;
      valid_r <= valid_r;
    end
  end

  assign pc    = pc_r;
  assign instr = instr_r;
  assign valid = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register, end-of-program detection,
// pipeline drain before raising end_program, and execution-time counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              IMEM_DEPTH   = 64,
  parameter logic [XLEN-1:0] RESET_PC     = {XLEN{1'b0}},
  parameter int              DRAIN_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          redirect,
  input  logic [XLEN-1:0]               redirect_pc,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_rdata,
  output logic [XLEN-1:0]               pc_current,
  output logic [XLEN-1:0]               if_id_pc,
  output logic [31:0]                   if_id_instr,
  output logic                          if_id_valid,
  output logic                          end_program,
  output logic [31:0]                   cycle_count,
  output logic [31:0]                   fetch_count
);

  localparam int              AW         = $clog2(IMEM_DEPTH);
  localparam int              DW         = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0]   DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] PC_LIMIT   = XLEN'(IMEM_DEPTH) << 2;
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  fetch_state_e    state_r, state_next_s;
  logic [XLEN-1:0] pc_r, pc_next_s;
  logic [DW-1:0]   drain_r, drain_next_s;
  logic            end_r, end_next_s;
  logic [31:0]     cycle_r, fetch_r;
  logic            load_s, flush_s, fetch_inc_s, end_hit_s;
  logic [XLEN-1:0] target_s;

  assign end_hit_s = (imem_rdata == END_INSTR) || (pc_r >= PC_LIMIT);
  assign target_s  = redirect_pc & ALIGN_MASK;

  // Next-state and IF/ID control; priority is redirect > stall > end > normal.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    drain_next_s = drain_r;
    end_next_s   = end_r;
    load_s       = 1'b0;
    flush_s      = 1'b0;
    fetch_inc_s  = 1'b0;
    case (state_r)
      RUN: begin
        drain_next_s = DRAIN_LOAD;
        if (redirect) begin
          pc_next_s = target_s;
          flush_s   = 1'b1;
        end else if (stall) begin
          pc_next_s = pc_r;
        end else if (end_hit_s) begin
          flush_s      = 1'b1;
          state_next_s = DRAIN;
        end else begin
          pc_next_s   = pc_r + PC_STEP;
          load_s      = 1'b1;
          fetch_inc_s = 1'b1;
        end
      end
      DRAIN: begin
        flush_s = 1'b1;
        // A redirect here means the end word was fetched down a wrong path.
        if (redirect) begin
          pc_next_s    = target_s;
          drain_next_s = DRAIN_LOAD;
          state_next_s = RUN;
        end else if (stall) begin
          drain_next_s = drain_r;
        end else if (drain_r == DW'(1)) begin
          drain_next_s = drain_r - DW'(1);
          state_next_s = DONE;
          end_next_s   = 1'b1;
        end else begin
          drain_next_s = drain_r - DW'(1);
        end
      end
      DONE: begin
        end_next_s = 1'b1;
      end
      default: begin
        state_next_s = RUN;
        drain_next_s = DRAIN_LOAD;
      end
    endcase
  end

  // Architectural state and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      pc_r    <= RESET_PC;
      drain_r <= DRAIN_LOAD;
      end_r   <= 1'b0;
      cycle_r <= 32'd0;
      fetch_r <= 32'd0;
    end else begin
      state_r <= state_next_s;
      pc_r    <= pc_next_s;
      drain_r <= drain_next_s;
      end_r   <= end_next_s;
      cycle_r <= sat_inc32(cycle_r);
      fetch_r <= fetch_inc_s ? sat_inc32(fetch_r) : fetch_r;
    end
  end

  pipe_reg_if_id u_if_id (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .flush    (flush_s),
    .pc_in    (pc_r),
    .instr_in (imem_rdata),
    .pc       (if_id_pc),
    .instr    (if_id_instr),
    .valid    (if_id_valid)
  );

  assign imem_addr   = pc_r[AW+1:2];
  assign pc_current  = pc_r;
  assign end_program = end_r;
  assign cycle_count = cycle_r;
  assign fetch_count = fetch_r;

endmodule
